pipe_chain: RTL and testbench

Parametrised elastic pipeline of DEPTH register stages carrying a WIDTH-bit payload, with per-stage valid bits, a valid/ready handshake at both ends, per-stage flush with bubble insertion, a global stall, and a live occupancy count. It is the next generation of the core's fixed stall/flush pipeline registers: a single instance can replace a run of stage registers between fetch and write-back and back-pressure the front end without a central stall controller.

---
 rtl/pipe_chain.sv | 123 ++++++++++++
 tb/tb_pipe_chain.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: elastic DEPTH-stage valid/ready pipeline with per-stage flush, global stall
// and live occupancy. Define PIPE_CHAIN_SKID_EN for a skid entry with registered in_ready.
module pipe_chain #(
    parameter int               DEPTH     = 4,
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RST_VALUE = WIDTH'(64'h0000_0000_0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       stall,
    input  logic [DEPTH-1:0]           flush,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 2);

    logic [DEPTH-1:0] stageValid;
    logic [WIDTH-1:0] stageData [DEPTH];
    logic [DEPTH-1:0] validNext;
    logic [WIDTH-1:0] dataNext [DEPTH];
    logic [WIDTH-1:0] feedData [DEPTH];
    logic [DEPTH-1:0] stageLoad;
    logic [DEPTH:0]   stageReady;
    logic             srcValid;
    logic [WIDTH-1:0] srcData;
    logic             skidValidNext;

    function automatic logic [OCC_W-1:0] countValid(input logic [DEPTH-1:0] v,
                                                    input logic skid);
        logic [OCC_W-1:0] n;
        n = OCC_W'(skid);
        for (int i = 0; i < DEPTH; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    // Ready ripples from the output back to the input; an empty stage breaks back-pressure.
    always_comb begin : readyChain
        logic rdy;
        rdy = out_ready & ~stall;
        stageReady[DEPTH] = rdy;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy = ~stall & (~stageValid[i] | rdy);
            stageReady[i] = rdy;
        end
    end

`ifdef PIPE_CHAIN_SKID_EN
    logic             skidValid;
    logic [WIDTH-1:0] skidData;

    assign in_ready      = ~skidValid;
    assign srcValid      = skidValid | in_valid;
    assign srcData       = skidValid ? skidData : in_data;
    assign skidValidNext = ~flush[0] & srcValid & ~stageReady[0];

    // Skid payload tracks in_data while empty, so it holds the parked beat once it fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skidValid <= 1'b0;
            skidData  <= RST_VALUE;
        end else begin
            skidValid <= skidValidNext;
            if (!skidValid) begin
                skidData <= in_data;
            end
        end
    end
`else
    assign in_ready      = stageReady[0];
    assign srcValid      = in_valid;
    assign srcData       = in_data;
    assign skidValidNext = 1'b0;
`endif

    // A flushed stage still hands its beat on for ready purposes but the beat is not loaded.
    always_comb begin
        feedData[0]  = srcData;
        stageLoad[0] = srcValid & stageReady[0];
        for (int i = 1; i < DEPTH; i++) begin
            feedData[i]  = stageData[i-1];
            stageLoad[i] = stageValid[i-1] & stageReady[i] & ~flush[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            validNext[i] = stageValid[i] & ~stageReady[i+1];
            dataNext[i]  = stageData[i];
            if (stageLoad[i]) begin
                validNext[i] = 1'b1;
                dataNext[i]  = feedData[i];
            end
            if (flush[i]) begin
                validNext[i] = 1'b0;
                dataNext[i]  = RST_VALUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stageValid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData[i] <= RST_VALUE;
            end
            occupancy <= '0;
        end else begin
            stageValid <= validNext;
            for (int i = 0; i < DEPTH; i++) begin
                stageData[i] <= dataNext[i];
            end
            occupancy <= countValid(validNext, skidValidNext);
        end
    end

    assign out_valid = stageValid[DEPTH-1] & ~stall;
    assign out_data  = stageData[DEPTH-1];

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: table-driven, hand-sequenced and randomized checks of pipe_chain
// (DEPTH=4, WIDTH=32) against a beat-position reference model.
`timescale 1ns/1ps
module tb_pipe_chain;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int OCC_W = $clog2(DEPTH + 2);
    localparam logic [WIDTH-1:0] NOP = 32'h13;
`ifdef PIPE_CHAIN_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic [DEPTH-1:0] flush;
    logic [OCC_W-1:0] occupancy;

    int nTests = 0;
    int nFail  = 0;
    logic [31:0] got [$];

    pipe_chain #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RST_VALUE(NOP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = '0;
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Records every output handshake for up to maxCyc cycles with inputs held as set.
    task automatic collect(input int maxCyc);
        got.delete();
        for (int c = 0; c < maxCyc; c++) begin
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            cyc();
        end
    endtask

    // ---------------- table-driven streaming + stall ----------------
    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        st;
        int          expIr;
        int          expOv;
        int          chkOd;
        logic [31:0] expOd;
        int          expOcc;
    } vec_t;
    vec_t tbl [$];

    task automatic addVec(input logic iv, input logic [31:0] id, input logic ordy, input logic st,
                          input int ir, input int ov, input int chk, input logic [31:0] od,
                          input int occ);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.st = st;
        v.expIr = ir; v.expOv = ov; v.chkOd = chk; v.expOd = od; v.expOcc = occ;
        tbl.push_back(v);
    endtask

    // ---------------- randomized run against a beat-position model ----------------
    typedef struct {
        logic [31:0] data;
        int          pos;   // -1 = skid entry, 0..DEPTH-1 = stage
    } beat_t;
    beat_t mq [$];

    task automatic randomRun(input int cycles);
        beat_t nq [$];
        beat_t b;
        int ahead, np, p;
        logic expOv, expIr, leave, hasSkid;
        logic [31:0] expOd, seqData;
        seqData = 32'h1000;
        mq.delete();
        for (int c = 0; c < cycles; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = seqData;
            out_ready = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 29) == 0) ? DEPTH'($urandom_range(1, 15)) : '0;

            expOv = !stall && mq.size() > 0 && mq[0].pos == DEPTH - 1;
            expOd = (mq.size() > 0) ? mq[0].data : 32'h0;
            leave = expOv && out_ready;
            // Every beat advances one place unless the beat ahead of it (after its own move) blocks it.
            nq.delete();
            ahead = DEPTH;
            foreach (mq[k]) begin
                if (k == 0 && leave) continue;
                p  = mq[k].pos;
                np = stall ? p : ((p + 1 < ahead - 1) ? p + 1 : ahead - 1);
                ahead = np;
                if (!((p >= 0 && flush[p]) || flush[np < 0 ? 0 : np])) begin
                    b.data = mq[k].data;
                    b.pos  = np;
                    nq.push_back(b);
                end
            end
            hasSkid = mq.size() > 0 && mq[mq.size()-1].pos == -1;
            expIr = (SKID != 0) ? !hasSkid : (!stall && ahead > 0);
            if (in_valid && expIr) begin
                np = stall ? -1 : ((ahead - 1 > 0) ? 0 : ahead - 1);
                if (!flush[0]) begin
                    b.data = in_data;
                    b.pos  = np;
                    nq.push_back(b);
                end
                seqData++;
            end

            #1;
            check("rnd in_ready", 32'(in_ready), 32'(expIr));
            check("rnd out_valid", 32'(out_valid), 32'(expOv));
            if (expOv) check("rnd out_data", out_data, expOd);
            cyc();
            mq = nq;
            check("rnd occupancy", 32'(occupancy), 32'(mq.size()));
        end
        idle();
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        idle();

        // Reset state
        doReset();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, NOP);
        check("reset occupancy", 32'(occupancy), 32'd0);
        stall = 1'b1;
        #1;
        check("reset in_ready stalled", 32'(in_ready), 32'(SKID));
        check("reset out_valid stalled", 32'(out_valid), 32'd0);
        stall = 1'b0;

        // Streaming 1..9 with a 3-cycle stall in the middle
        addVec(1, 1, 1, 0, 1, 0, 0, 0, 1);
        addVec(1, 2, 1, 0, 1, 0, 0, 0, 2);
        addVec(1, 3, 1, 0, 1, 0, 0, 0, 3);
        addVec(1, 4, 1, 0, 1, 0, 0, 0, 4);
        addVec(1, 5, 1, 0, 1, 1, 1, 1, 4);
        addVec(1, 6, 1, 0, 1, 1, 1, 2, 4);
        addVec(1, 7, 1, 0, 1, 1, 1, 3, 4);
        addVec(0, 0, 1, 1, SKID, 0, 1, 4, 4);
        addVec(0, 0, 1, 1, SKID, 0, 1, 4, 4);
        addVec(0, 0, 1, 1, SKID, 0, 1, 4, 4);
        addVec(1, 8, 1, 0, 1, 1, 1, 4, 4);
        addVec(1, 9, 1, 0, 1, 1, 1, 5, 4);
        addVec(0, 0, 1, 0, 1, 1, 1, 6, 3);
        addVec(0, 0, 1, 0, 1, 1, 1, 7, 2);
        addVec(0, 0, 1, 0, 1, 1, 1, 8, 1);
        addVec(0, 0, 1, 0, 1, 1, 1, 9, 0);
        addVec(0, 0, 1, 0, 1, 0, 0, 0, 0);
        doReset();
        foreach (tbl[k]) begin
            in_valid = tbl[k].iv; in_data = tbl[k].id;
            out_ready = tbl[k].ordy; stall = tbl[k].st;
            #1;
            check($sformatf("tbl[%0d] in_ready", k), 32'(in_ready), 32'(tbl[k].expIr));
            check($sformatf("tbl[%0d] out_valid", k), 32'(out_valid), 32'(tbl[k].expOv));
            if (tbl[k].chkOd != 0) check($sformatf("tbl[%0d] out_data", k), out_data, tbl[k].expOd);
            cyc();
            check($sformatf("tbl[%0d] occupancy", k), 32'(occupancy), 32'(tbl[k].expOcc));
        end
        idle();

        // Back-pressure fill: 6 beats offered with out_ready low
        doReset();
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (acc < 6);
            in_data  = 32'(20 + acc);
            #1;
            if (in_valid && in_ready) acc++;
            cyc();
        end
        check("bp accepted", 32'(acc), 32'(DEPTH + SKID));
        in_valid = 1'b1;
        #1;
        check("bp in_ready full", 32'(in_ready), 32'd0);
        check("bp occupancy full", 32'(occupancy), 32'(DEPTH + SKID));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect(12);
        check("bp delivered count", 32'(got.size()), 32'(DEPTH + SKID));
        for (int i = 0; i < DEPTH + SKID; i++)
            check($sformatf("bp order[%0d]", i), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, 32'(20 + i));
        idle();

        // Flush mid-chain: stage 1 holds 12
        doReset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(10 + i);
            cyc();
        end
        in_valid = 1'b0;
        check("fm occupancy before", 32'(occupancy), 32'd4);
        flush = 4'b0010;
        cyc();
        flush = '0;
        check("fm occupancy after", 32'(occupancy), 32'd3);
        check("fm stage1 valid", 32'(dut.stageValid[1]), 32'd0);
        check("fm stage1 data", dut.stageData[1], NOP);
        out_ready = 1'b1;
        collect(10);
        check("fm delivered count", 32'(got.size()), 32'd3);
        check("fm out[0]", (got.size() > 0) ? got[0] : 32'hxxxx_xxxx, 32'd10);
        check("fm out[1]", (got.size() > 1) ? got[1] : 32'hxxxx_xxxx, 32'd11);
        check("fm out[2]", (got.size() > 2) ? got[2] : 32'hxxxx_xxxx, 32'd13);
        idle();

        // Flush versus advance into stage 1
        doReset();
        in_valid = 1'b1;
        in_data  = 32'd50;
        cyc();
        in_valid = 1'b0;
        flush    = 4'b0010;
        cyc();
        flush = '0;
        check("fa occupancy", 32'(occupancy), 32'd0);
        check("fa stage1 valid", 32'(dut.stageValid[1]), 32'd0);
        check("fa stage1 data", dut.stageData[1], NOP);
        in_valid = 1'b1;
        in_data  = 32'd51;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect(8);
        check("fa delivered count", 32'(got.size()), 32'd1);
        check("fa out[0]", (got.size() > 0) ? got[0] : 32'hxxxx_xxxx, 32'd51);
        idle();

        // Asynchronous reset with 3 beats in flight
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(60 + i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        check("ar out_valid before", 32'(out_valid), 32'd1);
        check("ar occupancy before", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("ar out_valid", 32'(out_valid), 32'd0);
        check("ar occupancy", 32'(occupancy), 32'd0);
        check("ar out_data", out_data, NOP);
        check("ar in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst = 1'b0;
        #1;
        in_valid = 1'b1;
        in_data  = 32'd70;
        cyc();
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            check($sformatf("ar out_valid edge+%0d", j), 32'(out_valid), 32'(j == 3));
            if (j == 3) check("ar out_data", out_data, 32'd70);
            cyc();
        end
        idle();

        // Randomized traffic with stall, back-pressure and sporadic flushes
        doReset();
        randomRun(3000);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
